// File: rtl/data_sram_responder.sv
// data_sram_responder
//    Single-port 32-bit data memory answering the CPU data side over the
//    SRAM-like req/addr_ok + data_ok protocol. It holds one request at a time.
//    Writes commit with byte strobes on the handshake edge. The aligned word
//    comes back LATENCY cycles after the handshake.
//
// Ports
//    clk       clock, rising edge
//    rst       synchronous active-high reset
//    req       request valid
//    wr        1 = write, 0 = read
//    size      0 byte, 1 half, 2/3 word (alignment check only)
//    addr      byte address; word index = addr[ADDR_W+1:2]
//    wstrb     byte-lane enables for writes
//    wdata     write data, lanes aligned to the word
//    addr_ok   responder can accept this cycle (combinational)
//    data_ok   one-cycle response pulse
//    rdata     aligned word, valid with data_ok
//    misalign  alignment error flag, valid with data_ok
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing outstanding, accepting requests
// BUSY  | one request outstanding; countdown runs to the data_ok cycle
module data_sram_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        misalign
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam int         DEPTH  = 1 << ADDR_W;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
   localparam bit         LAT1   = (LATENCY == 1);

   state_t              state;
   logic [3:0]          cnt;
   logic [ADDR_W-1:0]   idx_q;
   logic                mis_q;
   logic [31:0]         mem [DEPTH];

   logic                hs;
   logic [ADDR_W-1:0]   idx;
   logic                mis_in;
   logic                do_write;
   logic [31:0]         cur_word;
   logic [31:0]         merged;
   logic                unused_addr;

   // Address bits above the array just alias.
   assign unused_addr = ^addr[31:ADDR_W+2];

   assign addr_ok  = (state == IDLE) || data_ok;
   assign hs       = req && addr_ok && !rst;
   assign idx      = addr[ADDR_W+1:2];
   assign do_write = hs && wr && !mis_in;
   assign cur_word = mem[idx];

   always_comb begin
      mis_in = 1'b0;
      case (size)
         2'd0:    mis_in = 1'b0;
         2'd1:    mis_in = addr[0];
         default: mis_in = |addr[1:0];
      endcase
   end

   always_comb begin
      merged = cur_word;
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) begin
            merged[8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

   // Array is deliberately not reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[idx] <= merged;
      end
   end

   // Writes are committed at the handshake, so only the index and the
   // alignment verdict have to survive until the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         idx_q    <= '0;
         mis_q    <= 1'b0;
         data_ok  <= 1'b0;
         rdata    <= 32'd0;
         misalign <= 1'b0;
      end else begin
         data_ok <= 1'b0;
         if (hs) begin
            state <= BUSY;
            cnt   <= LAT_M1;
            idx_q <= idx;
            mis_q <= mis_in;
            // With LATENCY = 1 the handshake edge also starts the data_ok
            // cycle, so the response must carry the word as just written.
            if (LAT1) begin
               data_ok  <= 1'b1;
               misalign <= mis_in;
               rdata    <= do_write ? merged : cur_word;
            end
         end else if (state == BUSY) begin
            if (data_ok) begin
               state <= IDLE;
            end else begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end
               if (cnt == 4'd1) begin
                  data_ok  <= 1'b1;
                  misalign <= mis_q;
                  rdata    <= mem[idx_q];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: three instances with LATENCY 1, 2, 3.
// A cycle-level reference model (handshake times, due cycles, word array)
// is compared against every instance on each falling edge; directed tests
// add literal expectations.
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_s      [3];
   logic        wr_s       [3];
   logic [1:0]  size_s     [3];
   logic [31:0] addr_s     [3];
   logic [3:0]  wstrb_s    [3];
   logic [31:0] wdata_s    [3];
   logic        addr_ok_s  [3];
   logic        data_ok_s  [3];
   logic [31:0] rdata_s    [3];
   logic        misalign_s [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_sram_responder #(.ADDR_W(10), .LATENCY(g + 1)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .req      (req_s[g]),
         .wr       (wr_s[g]),
         .size     (size_s[g]),
         .addr     (addr_s[g]),
         .wstrb    (wstrb_s[g]),
         .wdata    (wdata_s[g]),
         .addr_ok  (addr_ok_s[g]),
         .data_ok  (data_ok_s[g]),
         .rdata    (rdata_s[g]),
         .misalign (misalign_s[g])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 1'b0;
      if (sz == 2'd1) return (a % 2) != 0;
      return (a % 4) != 0;
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mmem   [3][1024];
   bit          mknown [3][1024];
   bit          m_busy [3];
   int          m_due  [3];
   logic [31:0] m_exp  [3];
   bit          m_expk [3];
   bit          m_mis  [3];
   int          cyc = 0;
   bit          started = 1'b0;
   bit          e_aok, e_dok, e_mis;
   int          e_ix;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         e_aok = !m_busy[k] || (m_due[k] == cyc);
         e_dok = m_busy[k] && (m_due[k] == cyc);
         if (started) begin
            chk($sformatf("addr_ok[L%0d] cyc%0d", k + 1, cyc), 32'(addr_ok_s[k]), 32'(e_aok));
            chk($sformatf("data_ok[L%0d] cyc%0d", k + 1, cyc), 32'(data_ok_s[k]), 32'(e_dok));
            if (e_dok) begin
               chk($sformatf("misalign[L%0d] cyc%0d", k + 1, cyc), 32'(misalign_s[k]), 32'(m_mis[k]));
               if (m_expk[k]) begin
                  chk($sformatf("rdata[L%0d] cyc%0d", k + 1, cyc), rdata_s[k], m_exp[k]);
               end
            end
         end
         if (rst) begin
            m_busy[k] = 1'b0;
         end else begin
            if (e_dok) m_busy[k] = 1'b0;
            if (req_s[k] && e_aok) begin
               e_ix  = int'(addr_s[k][11:2]);
               e_mis = misaligned(size_s[k], addr_s[k]);
               if (wr_s[k] && !e_mis) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wstrb_s[k][b]) mmem[k][e_ix][8*b +: 8] = wdata_s[k][8*b +: 8];
                  end
                  if (wstrb_s[k] == 4'hF) mknown[k][e_ix] = 1'b1;
               end
               m_exp[k]  = mmem[k][e_ix];
               m_expk[k] = mknown[k][e_ix];
               m_mis[k]  = e_mis;
               m_busy[k] = 1'b1;
               m_due[k]  = cyc + k + 1;
            end
         end
      end
      if (rst) started = 1'b1;
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
   task automatic issue(input int k, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [3:0] sb,
                        input logic [31:0] d, output int waits);
      bit done;
      req_s[k] = 1'b1; wr_s[k] = w; size_s[k] = sz;
      addr_s[k] = a; wstrb_s[k] = sb; wdata_s[k] = d;
      waits = 0;
      done  = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (addr_ok_s[k]) begin
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 64) begin
               checks++; errors++;
               $display("FAIL issue_timeout L%0d addr=%h actual=no_addr_ok required=addr_ok", k + 1, a);
               done = 1'b1;
            end
         end
      end
      sync();
   endtask

   task automatic wait_resp(input int k, output logic [31:0] rd, output logic mis, output int lat);
      bit done;
      lat  = 1;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (data_ok_s[k]) begin
            done = 1'b1;
         end else begin
            lat++;
            if (lat > 40) begin
               checks++; errors++;
               $display("FAIL resp_timeout L%0d actual=no_data_ok required=data_ok", k + 1);
               done = 1'b1;
            end
         end
      end
      rd  = rdata_s[k];
      mis = misalign_s[k];
   endtask

   task automatic txn(input int k, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [3:0] sb, input logic [31:0] d,
                      output logic [31:0] rd, output logic mis, output int lat);
      int wt;
      issue(k, w, sz, a, sb, d, wt);
      req_s[k] = 1'b0;
      wait_resp(k, rd, mis, lat);
      sync();
   endtask

   // ---------------- main sequence ----------------
   logic [31:0] rd, a, d, r;
   logic        mis;
   int          lat, wt, gap, hs_n, dok_n;
   int          hs_c [2];

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_s[k] = 1'b0; wr_s[k] = 1'b0; size_s[k] = 2'd0;
         addr_s[k] = 32'd0; wstrb_s[k] = 4'd0; wdata_s[k] = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_addr_ok L%0d", k + 1), 32'(addr_ok_s[k]), 32'd1);
         chk($sformatf("reset_data_ok L%0d", k + 1), 32'(data_ok_s[k]), 32'd0);
         chk($sformatf("reset_rdata L%0d", k + 1), rdata_s[k], 32'd0);
      end
      sync();

      // LATENCY = 2: word write then read
      txn(1, 1'b1, 2'd2, 32'h10, 4'hF, 32'h12345678, rd, mis, lat);
      chk("wr_latency", 32'(lat), 32'd2);
      txn(1, 1'b0, 2'd2, 32'h10, 4'h0, 32'h0, rd, mis, lat);
      chk("rd_latency", 32'(lat), 32'd2);
      chk("rd_word", rd, 32'h12345678);
      chk("rd_word_mis", 32'(mis), 32'd0);

      // byte strobe
      txn(1, 1'b1, 2'd2, 32'h20, 4'hF, 32'hAABBCCDD, rd, mis, lat);
      txn(1, 1'b1, 2'd0, 32'h21, 4'h2, 32'h00001100, rd, mis, lat);
      chk("strobe_wr_resp", rd, 32'hAABB11DD);
      txn(1, 1'b0, 2'd2, 32'h20, 4'h0, 32'h0, rd, mis, lat);
      chk("strobe_rd", rd, 32'hAABB11DD);

      // misaligned half write
      txn(1, 1'b1, 2'd1, 32'h21, 4'h3, 32'hFFFFFFFF, rd, mis, lat);
      chk("mis_wr_flag", 32'(mis), 32'd1);
      txn(1, 1'b0, 2'd2, 32'h20, 4'h0, 32'h0, rd, mis, lat);
      chk("mis_rd_word", rd, 32'hAABB11DD);
      chk("mis_rd_flag", 32'(mis), 32'd0);

      // address wrap
      txn(1, 1'b1, 2'd2, 32'h0000_1000, 4'hF, 32'hCAFEF00D, rd, mis, lat);
      txn(1, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, rd, mis, lat);
      chk("wrap_rd", rd, 32'hCAFEF00D);

      // reset mid-flight
      txn(1, 1'b1, 2'd2, 32'h14, 4'hF, 32'h5A5A0005, rd, mis, lat);
      issue(1, 1'b0, 2'd2, 32'h30, 4'h0, 32'h0, wt);
      req_s[1] = 1'b0;
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_data_ok", 32'(data_ok_s[1]), 32'd0);
      chk("rst_mid_rdata", rdata_s[1], 32'd0);
      chk("rst_mid_addr_ok", 32'(addr_ok_s[1]), 32'd1);
      sync();
      repeat (3) sync();
      txn(1, 1'b0, 2'd2, 32'h14, 4'h0, 32'h0, rd, mis, lat);
      chk("rst_persist", rd, 32'h5A5A0005);

      // LATENCY = 1: back-to-back reads
      for (int i = 0; i < 8; i++) begin
         txn(0, 1'b1, 2'd2, 32'h40 + 32'(4 * i), 4'hF, 32'h1000_0000 + 32'(i), rd, mis, lat);
      end
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               issue(0, 1'b0, 2'd2, 32'h40 + 32'(4 * i), 4'h0, 32'h0, wt);
               chk($sformatf("b2b_wait%0d", i), 32'(wt), 32'd0);
            end
            req_s[0] = 1'b0;
         end
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (!data_ok_s[0] && n < 10) begin
               n++;
               @(negedge clk);
            end
            for (int j = 0; j < 8; j++) begin
               if (j > 0) @(negedge clk);
               chk($sformatf("b2b_data_ok%0d", j), 32'(data_ok_s[0]), 32'd1);
               chk($sformatf("b2b_rdata%0d", j), rdata_s[0], 32'h1000_0000 + 32'(j));
            end
         end
      join
      repeat (3) sync();

      // LATENCY = 3: held req
      hs_n = 0; dok_n = 0; hs_c[0] = 0; hs_c[1] = 0;
      req_s[2] = 1'b1; wr_s[2] = 1'b0; size_s[2] = 2'd2; addr_s[2] = 32'h0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (req_s[2] && addr_ok_s[2]) begin
            if (hs_n < 2) hs_c[hs_n] = c;
            hs_n++;
         end
         if (data_ok_s[2]) dok_n++;
         sync();
         if (c == 5) req_s[2] = 1'b0;
      end
      chk("stall_handshakes", 32'(hs_n), 32'd2);
      chk("stall_spacing", 32'(hs_c[1] - hs_c[0]), 32'd3);
      chk("stall_data_ok", 32'(dok_n), 32'd2);

      // randomized traffic on every instance
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 32; i++) begin
            txn(k, 1'b1, 2'd2, 32'(4 * i), 4'hF, $urandom(), rd, mis, lat);
         end
         for (int t = 0; t < 150; t++) begin
            a = $urandom();
            a[11:7] = 5'd0;
            d = $urandom();
            r = $urandom();
            issue(k, r[0], r[2:1], a, r[6:3], d, wt);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
               req_s[k] = 1'b0;
               repeat (gap) sync();
            end
         end
         req_s[k] = 1'b0;
         repeat (8) sync();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
